alu: RTL and testbench

- Registered 32-bit integer ALU for the RISC-V datapath.
- Computes one of ten operations selected by a 4-bit opcode on operands A and B.
- The result is registered and appears one clock cycle after the operands are sampled.
- Pure datapath: no handshake and no status flags.

---
 rtl/alu.sv | 77 +++++++
 tb/tb_alu.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered integer ALU for the RISC-V datapath.
// One operation per cycle, result valid one clock after the operands are sampled.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_op_i,
  input  logic [WIDTH-1:0] alu_a_i,
  input  logic [WIDTH-1:0] alu_b_i,
  output logic [WIDTH-1:0] alu_result_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_AND  = 4'h1,
    OP_SLL  = 4'h2,
    OP_SRL  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_SGEU = 4'h7,
    OP_ROR  = 4'h8,
    OP_LUI  = 4'h9
  } alu_op_e;

  logic [SHW-1:0]   shamt;
  logic [SHW:0]     rot_lshamt;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] ror_res;
  logic             slt_bit;
  logic             sgeu_bit;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  // Shift/rotate and compare helpers shared by the opcode mux
  always_comb begin
    shamt      = alu_b_i[SHW-1:0];
    // Left-shift complement for the rotate; shamt = 0 gives WIDTH, which shifts A out entirely
    rot_lshamt = (SHW+1)'(WIDTH) - {1'b0, shamt};
    sll_res    = alu_a_i << shamt;
    srl_res    = alu_a_i >> shamt;
    ror_res    = (alu_a_i >> shamt) | (alu_a_i << rot_lshamt);
    slt_bit    = $signed(alu_a_i) < $signed(alu_b_i);
    sgeu_bit   = alu_a_i >= alu_b_i;
  end

  // Opcode select; unused opcodes return zero
  always_comb begin
    result_d = '0;
    case (alu_op_i)
      OP_ADD:  result_d = alu_a_i + alu_b_i;
      OP_AND:  result_d = alu_a_i & alu_b_i;
      OP_SLL:  result_d = sll_res;
      OP_SRL:  result_d = srl_res;
      OP_OR:   result_d = alu_a_i | alu_b_i;
      OP_XOR:  result_d = alu_a_i ^ alu_b_i;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SGEU: result_d = {{(WIDTH-1){1'b0}}, sgeu_bit};
      OP_ROR:  result_d = ror_res;
      OP_LUI:  result_d = {alu_b_i[7:0], {(WIDTH-8){1'b0}}};
      default: result_d = '0;
    endcase
  end

  // Result register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign alu_result_o = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_op_i;
  logic [31:0] alu_a_i;
  logic [31:0] alu_b_i;
  logic [31:0] alu_result_o;

  int n_cmp;
  int n_err;

  alu #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_op_i     (alu_op_i),
    .alu_a_i      (alu_a_i),
    .alu_b_i      (alu_b_i),
    .alu_result_o (alu_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands, then step to 1 time unit after the next rising edge
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op_i = op;
    alu_a_i  = a;
    alu_b_i  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    alu_op_i = 4'h0; alu_a_i = 32'd3; alu_b_i = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (alu_result_o !== 32'h0) begin
      n_err++; $display("FAIL reset_hold got %h want %h", alu_result_o, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (alu_result_o !== 32'h0) begin
      n_err++; $display("FAIL reset_release got %h want %h", alu_result_o, 32'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (alu_result_o !== 32'h7) begin
      n_err++; $display("FAIL first_add got %h want %h", alu_result_o, 32'h7);
    end
    // Mid-cycle reset must clear at once
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (alu_result_o !== 32'h0) begin
      n_err++; $display("FAIL async_clear got %h want %h", alu_result_o, 32'h0);
    end
    alu_op_i = 4'h5; alu_a_i = 32'hFF; alu_b_i = 32'h0F;
    @(negedge clk);
    rst_n = 1'b1;
    alu_op_i = 4'h0; alu_a_i = 32'd1; alu_b_i = 32'd2;
    @(posedge clk); #1;
    n_cmp++;
    if (alu_result_o !== 32'h3) begin
      n_err++; $display("FAIL post_reset_first got %h want %h", alu_result_o, 32'h3);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    logic [31:0] a  [6] = '{32'h3, 32'h13, 32'hC0000030, 32'h31, 32'h13, 32'h13};
    logic [31:0] b  [6] = '{32'h4, 32'h15, 32'h3, 32'h3, 32'h15, 32'h15};
    logic [31:0] ex [6] = '{32'h7, 32'h11, 32'h00000180, 32'h6, 32'h17, 32'h06};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++;
      if (alu_result_o !== ex[i]) begin
        n_err++; $display("FAIL b2b_%0d got %h want %h", i, alu_result_o, ex[i]);
      end
    end
  endtask

  task automatic test_compare;
    logic [3:0]  op [7] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h7, 4'h7, 4'h7};
    logic [31:0] a  [7] = '{32'h13, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h13, 32'hFFFFFFFF, 32'h42};
    logic [31:0] b  [7] = '{32'h15, 32'h1, 32'h80000000, 32'h5, 32'h15, 32'h1, 32'h42};
    logic [31:0] ex [7] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1};
    for (int i = 0; i < 7; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++;
      if (alu_result_o !== ex[i]) begin
        n_err++; $display("FAIL cmp_%0d got %h want %h", i, alu_result_o, ex[i]);
      end
    end
  endtask

  task automatic test_rotate_lui;
    logic [3:0]  op [6] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h9, 4'h9};
    logic [31:0] a  [6] = '{32'h80000030, 32'h80000030, 32'h80000030, 32'h12345678, 32'h80000030, 32'hFFFFFFFF};
    logic [31:0] b  [6] = '{32'h4, 32'h0, 32'd36, 32'h8, 32'h56, 32'hFFFFFFA5};
    logic [31:0] ex [6] = '{32'h08000003, 32'h80000030, 32'h08000003, 32'h78123456, 32'h56000000, 32'hA5000000};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++;
      if (alu_result_o !== ex[i]) begin
        n_err++; $display("FAIL rot_lui_%0d got %h want %h", i, alu_result_o, ex[i]);
      end
    end
  endtask

  task automatic test_arith_edges;
    logic [3:0]  op [6] = '{4'h0, 4'h2, 4'h3, 4'h2, 4'h3, 4'h0};
    logic [31:0] a  [6] = '{32'hFFFFFFFF, 32'h3, 32'h80000000, 32'h5, 32'hF0000000, 32'h7FFFFFFF};
    logic [31:0] b  [6] = '{32'h1, 32'd31, 32'd31, 32'd32, 32'd4, 32'h1};
    logic [31:0] ex [6] = '{32'h0, 32'h80000000, 32'h1, 32'h5, 32'h0F000000, 32'h80000000};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++;
      if (alu_result_o !== ex[i]) begin
        n_err++; $display("FAIL edge_%0d got %h want %h", i, alu_result_o, ex[i]);
      end
    end
  endtask

  task automatic test_undefined_ops;
    // Prime the output non-zero so a stuck register is visible
    drive(4'h4, 32'hFFFFFFFF, 32'h0);
    for (int i = 10; i < 16; i++) begin
      drive(4'(i), 32'hFFFFFFFF, 32'hFFFFFFFF);
      n_cmp++;
      if (alu_result_o !== 32'h0) begin
        n_err++; $display("FAIL undef_op_%0h got %h want %h", i, alu_result_o, 32'h0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_compare();
    test_rotate_lui();
    test_arith_edges();
    test_undefined_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
